cp0_exc_ctrl: RTL and testbench

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_exc_ctrl_pkg.sv | 50 +++++
 rtl/cp0_exc_prio.sv | 42 ++++
 rtl/cp0_exc_ctrl.sv | 131 +++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, exc_type bit
// positions and the selection result passed from the priority encoder.
package cp0_exc_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned EXC_W = 5;

  localparam logic [REG_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [REG_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [REG_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [REG_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [REG_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [REG_W-1:0] CP0_EPC      = 5'd14;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'h00;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'h0A;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'h0C;
  localparam logic [EXC_W-1:0] EXC_TR   = 5'h0D;

  localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // exc_type_i bit positions
  localparam int unsigned EB_IF      = 0;
  localparam int unsigned EB_RI      = 1;
  localparam int unsigned EB_OV      = 2;
  localparam int unsigned EB_TP      = 3;
  localparam int unsigned EB_BREAK   = 4;
  localparam int unsigned EB_SYSCALL = 5;
  localparam int unsigned EB_ADE     = 6;
  localparam int unsigned EB_ERET    = 7;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned CA_BD  = 31;

  localparam logic [XLEN-1:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;

  typedef struct packed {
    logic             taken;
    logic             is_eret;
    logic [EXC_W-1:0] exccode;
  } exc_sel_t;

endpackage

// File: rtl/cp0_exc_prio.sv
// Fixed-priority exception selector; ADE reports AdEL and the parent
// turns it into AdES for stores.
module cp0_exc_prio
  import cp0_exc_ctrl_pkg::*;
(
  input  logic [7:0] exc_type,
  input  logic       int_pending,
  output exc_sel_t   sel
);

  always_comb begin
    sel = '0;
    if (int_pending) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_INT;
    end else if (exc_type[EB_IF]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_ADEL;
    end else if (exc_type[EB_RI]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_RI;
    end else if (exc_type[EB_OV]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_OV;
    end else if (exc_type[EB_SYSCALL]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_SYS;
    end else if (exc_type[EB_BREAK]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_BP;
    end else if (exc_type[EB_TP]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_TR;
    end else if (exc_type[EB_ADE]) begin
      sel.taken   = 1'b1;
      sel.exccode = EXC_ADEL;
    end else if (exc_type[EB_ERET]) begin
      sel.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with exception/ERET control for the MEM stage:
// combinational flush/redirect, register commit at the next edge.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [7:0]  exc_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic        is_store_i,
  input  logic [31:0] bad_vaddr_i,
  input  logic [5:0]  int_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_rdata_o,
  output logic        flush_o,
  output logic [31:0] exc_pc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [XLEN-1:0]  badvaddr_q, count_q, compare_q, status_q, cause_q, epc_q;
  logic             tick_q, timer_int_q;
  logic [7:0]       exc_gated;
  logic             int_pending;
  exc_sel_t         sel;
  logic             exc_taken, eret_taken, wr_en, from_ade, exl;
  logic [EXC_W-1:0] exccode_c;

  assign exc_gated   = valid_i ? exc_type_i : 8'h00;
  assign int_pending = valid_i & status_q[ST_IE] & ~status_q[ST_EXL]
                     & (|(cause_q[15:8] & status_q[15:8]));

  cp0_exc_prio u_prio (
    .exc_type    (exc_gated),
    .int_pending (int_pending),
    .sel         (sel)
  );

  // Nothing is taken while reset is held, so outputs read as idle.
  assign exc_taken  = rst_n & sel.taken;
  assign eret_taken = rst_n & sel.is_eret;
  assign from_ade   = (sel.exccode == EXC_ADEL) & ~exc_gated[EB_IF];
  assign exccode_c  = (from_ade && is_store_i) ? EXC_ADES : sel.exccode;
  assign exl        = status_q[ST_EXL];

  assign flush_o  = exc_taken | eret_taken;
  assign exc_pc_o = exc_taken ? EXC_VECTOR : (eret_taken ? epc_q : 32'h0);
  assign wr_en    = cp0_we_i & ~flush_o;

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;

  // Count/Compare and the timer interrupt latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      tick_q      <= 1'b0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      if (wr_en && cp0_waddr_i == CP0_COUNT) begin
        count_q <= cp0_wdata_i;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= ~tick_q;
        if (tick_q) count_q <= count_q + 32'd1;
      end
      if (wr_en && cp0_waddr_i == CP0_COMPARE) begin
        compare_q   <= cp0_wdata_i;
        timer_int_q <= 1'b0;
      end else if (count_q == compare_q && compare_q != '0) begin
        timer_int_q <= 1'b1;
      end
    end
  end

  // Status, Cause, EPC and BadVAddr, including exception/ERET commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      cause_q[15:10] <= {int_i[5] | timer_int_q, int_i[4:0]};
      if (exc_taken) begin
        status_q[ST_EXL] <= 1'b1;
        cause_q[6:2]     <= exccode_c;
        if (!exl) begin
          cause_q[CA_BD] <= in_delay_slot_i;
          epc_q          <= in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
        end
        if (sel.exccode == EXC_ADEL)
          badvaddr_q <= exc_gated[EB_IF] ? pc_i : bad_vaddr_i;
      end else if (eret_taken) begin
        status_q[ST_EXL] <= 1'b0;
      end else if (wr_en) begin
        case (cp0_waddr_i)
          CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (cp0_wdata_i & STATUS_WMASK);
          CP0_CAUSE:  cause_q[9:8] <= cp0_wdata_i[9:8];
          CP0_EPC:    epc_q <= cp0_wdata_i;
          default:    ;
        endcase
      end
    end
  end

  // MFC0 read port, straight from register state
  always_comb begin
    cp0_rdata_o = '0;
    case (cp0_raddr_i)
      CP0_BADVADDR: cp0_rdata_o = badvaddr_q;
      CP0_COUNT:    cp0_rdata_o = count_q;
      CP0_COMPARE:  cp0_rdata_o = compare_q;
      CP0_STATUS:   cp0_rdata_o = status_q;
      CP0_CAUSE:    cp0_rdata_o = cause_q;
      CP0_EPC:      cp0_rdata_o = epc_q;
      default:      cp0_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exceptions, priority, nesting, ERET,
// timer interrupt and reset behaviour with hand-computed expectations.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [7:0]  exc_type_i;
  logic [31:0] pc_i;
  logic        in_delay_slot_i;
  logic        is_store_i;
  logic [31:0] bad_vaddr_i;
  logic [5:0]  int_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [4:0]  cp0_raddr_i;
  logic [31:0] cp0_rdata_o;
  logic        flush_o;
  logic [31:0] exc_pc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  cp0_exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .exc_type_i(exc_type_i),
    .pc_i(pc_i), .in_delay_slot_i(in_delay_slot_i), .is_store_i(is_store_i),
    .bad_vaddr_i(bad_vaddr_i), .int_i(int_i), .cp0_we_i(cp0_we_i),
    .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .cp0_raddr_i(cp0_raddr_i), .cp0_rdata_o(cp0_rdata_o), .flush_o(flush_o),
    .exc_pc_o(exc_pc_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i         = 1'b0;
    exc_type_i      = 8'h00;
    pc_i            = 32'h0;
    in_delay_slot_i = 1'b0;
    is_store_i      = 1'b0;
    bad_vaddr_i     = 32'h0;
    cp0_we_i        = 1'b0;
    cp0_waddr_i     = 5'd0;
    cp0_wdata_i     = 32'h0;
    cp0_raddr_i     = 5'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we_i    = 1'b1;
    cp0_waddr_i = a;
    cp0_wdata_i = d;
    cyc();
    cp0_we_i    = 1'b0;
  endtask

  task automatic drive_exc(input logic [7:0] t, input logic [31:0] pc, input logic ds);
    valid_i         = 1'b1;
    exc_type_i      = t;
    pc_i            = pc;
    in_delay_slot_i = ds;
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    cp0_raddr_i = a;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    int_i = 6'd0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0h exp=0", flush_o); end
    total++; if (exc_pc_o !== 32'h0) begin bad++; $display("FAIL reset_exc_pc got=%h exp=0", exc_pc_o); end
    total++; if (status_o !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h exp=00400000", status_o); end
    total++; if (cause_o !== 32'h0 || epc_o !== 32'h0 || cp0_rdata_o !== 32'h0) begin
      bad++; $display("FAIL reset_zero cause=%h epc=%h rdata=%h exp=0", cause_o, epc_o, cp0_rdata_o);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_syscall();
    drive_exc(8'h20, 32'h8000_0100, 1'b0);
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL sys_flush got=%0h exp=1", flush_o); end
    total++; if (exc_pc_o !== VEC) begin bad++; $display("FAIL sys_exc_pc got=%h exp=%h", exc_pc_o, VEC); end
    cyc(); idle(); #1;
    total++; if (epc_o !== 32'h8000_0100) begin bad++; $display("FAIL sys_epc got=%h exp=80000100", epc_o); end
    total++; if (cause_o[6:2] !== 5'h08) begin bad++; $display("FAIL sys_exccode got=%h exp=08", cause_o[6:2]); end
    total++; if (status_o[1] !== 1'b1) begin bad++; $display("FAIL sys_exl got=%0h exp=1", status_o[1]); end
    mtc0(5'd12, 32'h0);
    total++; if (status_o !== 32'h0040_0000) begin bad++; $display("FAIL status_write got=%h exp=00400000", status_o); end
  endtask

  task automatic test_delay_slot_ri();
    drive_exc(8'h02, 32'h8000_0204, 1'b1);
    cyc(); idle(); #1;
    total++; if (epc_o !== 32'h8000_0200) begin bad++; $display("FAIL ds_epc got=%h exp=80000200", epc_o); end
    total++; if (cause_o[31] !== 1'b1) begin bad++; $display("FAIL ds_bd got=%0h exp=1", cause_o[31]); end
    total++; if (cause_o[6:2] !== 5'h0A) begin bad++; $display("FAIL ds_exccode got=%h exp=0a", cause_o[6:2]); end
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_priority();
    drive_exc(8'h26, 32'h8000_0010, 1'b0);
    cyc(); idle(); #1;
    total++; if (cause_o[6:2] !== 5'h0A) begin bad++; $display("FAIL prio_ri got=%h exp=0a", cause_o[6:2]); end
    int_i = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    #1;
    total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL prio_bubble_int got=%0h exp=0", flush_o); end
    drive_exc(8'h26, 32'h8000_0020, 1'b0);
    total++; if (flush_o !== 1'b1 || exc_pc_o !== VEC) begin
      bad++; $display("FAIL prio_int_flush got=%0h/%h exp=1/%h", flush_o, exc_pc_o, VEC);
    end
    cyc(); idle(); #1;
    total++; if (cause_o[6:2] !== 5'h00) begin bad++; $display("FAIL prio_int got=%h exp=00", cause_o[6:2]); end
    total++; if (cause_o[31] !== 1'b0 || epc_o !== 32'h8000_0020) begin
      bad++; $display("FAIL prio_int_epc bd=%0h epc=%h exp=0/80000020", cause_o[31], epc_o);
    end
    int_i = 6'd0;
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_ade_store();
    is_store_i  = 1'b1;
    bad_vaddr_i = 32'h0000_1001;
    drive_exc(8'h40, 32'h8000_0300, 1'b0);
    cyc(); idle(); rd(5'd8);
    total++; if (cause_o[6:2] !== 5'h05) begin bad++; $display("FAIL ades_exccode got=%h exp=05", cause_o[6:2]); end
    total++; if (cp0_rdata_o !== 32'h0000_1001) begin bad++; $display("FAIL ades_badvaddr got=%h exp=00001001", cp0_rdata_o); end
    total++; if (epc_o !== 32'h8000_0300) begin bad++; $display("FAIL ades_epc got=%h exp=80000300", epc_o); end
  endtask

  task automatic test_nested_eret();
    drive_exc(8'h20, 32'h8000_0400, 1'b1);
    cyc(); idle(); #1;
    total++; if (epc_o !== 32'h8000_0300 || cause_o[31] !== 1'b0) begin
      bad++; $display("FAIL nest_epc epc=%h bd=%0h exp=80000300/0", epc_o, cause_o[31]);
    end
    total++; if (cause_o[6:2] !== 5'h08) begin bad++; $display("FAIL nest_exccode got=%h exp=08", cause_o[6:2]); end
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'hDEAD_BEEF;
    drive_exc(8'h80, 32'h8000_0500, 1'b0);
    total++; if (flush_o !== 1'b1 || exc_pc_o !== 32'h8000_0300) begin
      bad++; $display("FAIL eret_redirect got=%0h/%h exp=1/80000300", flush_o, exc_pc_o);
    end
    cyc(); idle(); #1;
    total++; if (status_o[1] !== 1'b0) begin bad++; $display("FAIL eret_exl got=%0h exp=0", status_o[1]); end
    total++; if (epc_o !== 32'h8000_0300) begin bad++; $display("FAIL eret_wr_discard got=%h exp=80000300", epc_o); end
    exc_type_i = 8'h80; valid_i = 1'b0; #1;
    total++; if (flush_o !== 1'b0 || exc_pc_o !== 32'h0) begin
      bad++; $display("FAIL eret_bubble got=%0h/%h exp=0/0", flush_o, exc_pc_o);
    end
    idle();
  endtask

  task automatic test_timer();
    int hit;
    hit = 0;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd10);
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (cause_o[15] === 1'b1 && hit == 0) hit = n;
    end
    total++; if (hit != 21) begin bad++; $display("FAIL timer_ip7_cycle got=%0d exp=21", hit); end
    rd(5'd11);
    total++; if (cp0_rdata_o !== 32'd10) begin bad++; $display("FAIL read_compare got=%h exp=0000000a", cp0_rdata_o); end
    rd(5'd10);
    total++; if (cp0_rdata_o !== 32'h0) begin bad++; $display("FAIL read_unmapped got=%h exp=0", cp0_rdata_o); end
    drive_exc(8'h00, 32'h8000_0600, 1'b0);
    total++; if (flush_o !== 1'b1 || exc_pc_o !== VEC) begin
      bad++; $display("FAIL timer_int_flush got=%0h/%h exp=1/%h", flush_o, exc_pc_o, VEC);
    end
    cyc(); idle(); #1;
    total++; if (cause_o[6:2] !== 5'h00 || epc_o !== 32'h8000_0600) begin
      bad++; $display("FAIL timer_int_commit code=%h epc=%h exp=00/80000600", cause_o[6:2], epc_o);
    end
    mtc0(5'd11, 32'd1000);
    cyc();
    total++; if (cause_o[15] !== 1'b0) begin bad++; $display("FAIL timer_clear got=%0h exp=0", cause_o[15]); end
  endtask

  task automatic test_reset_mid();
    drive_exc(8'h20, 32'h8000_0700, 1'b0);
    rst_n = 1'b0; #1;
    total++; if (flush_o !== 1'b0 || exc_pc_o !== 32'h0) begin
      bad++; $display("FAIL rstmid_flush got=%0h/%h exp=0/0", flush_o, exc_pc_o);
    end
    total++; if (status_o !== 32'h0040_0000 || epc_o !== 32'h0 || cause_o !== 32'h0) begin
      bad++; $display("FAIL rstmid_regs st=%h epc=%h cause=%h exp=00400000/0/0", status_o, epc_o, cause_o);
    end
    cyc(); idle();
    rst_n = 1'b1;
    cyc(); rd(5'd9);
    total++; if (cp0_rdata_o !== 32'h0 || epc_o !== 32'h0 || status_o !== 32'h0040_0000) begin
      bad++; $display("FAIL rstmid_resume count=%h epc=%h st=%h exp=0/0/00400000", cp0_rdata_o, epc_o, status_o);
    end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_delay_slot_ri();
    test_priority();
    test_ade_store();
    test_nested_eret();
    test_timer();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
